// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Brief    : Loads a framed program image from the UART RX FIFO into imem,
//            acks each frame on the TX FIFO and releases the core on success.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              owns_uart
);

    localparam int          TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [7:0]  C_SYNC    = 8'hA5;
    localparam logic [7:0]  C_ACK_OK  = 8'h4B;
    localparam logic [7:0]  C_ACK_ERR = 8'h45;
    localparam logic [7:0]  C_ACK_TO  = 8'h54;
    localparam logic [16:0] C_MAX_N   = 17'(2 ** ADDR_W);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]       r_state, w_state_nxt;
    logic [15:0]      r_len;
    logic [CNT_W-1:0] r_word_cnt;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_chk;
    logic [7:0]       r_ack;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_cpu_reset;
    logic             r_owns_uart;

    logic             w_accept, w_in_frame, w_timeout, w_wr, w_ack_set, w_last;
    logic [7:0]       w_ack_val;
    logic [15:0]      w_len;
    logic [CNT_W-1:0] w_word_nxt;

    assign w_word_nxt = r_word_cnt + CNT_W'(1);
    assign w_last     = (32'(w_word_nxt) == 32'(r_len));
    assign w_len      = {r_data, r_len[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_ack_set   = 1'b0;
        w_ack_val   = r_ack;
        w_in_frame  = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
        w_accept    = (w_in_frame || (r_state == S_SYNC)) && !rx_empty;
        // A byte present in the expiry cycle wins over the timeout.
        w_timeout   = w_in_frame && rx_empty && (r_to_cnt == C_TO_LAST);
        case (r_state)
            S_SYNC: if (w_accept && (r_data == C_SYNC)) w_state_nxt = S_LEN0;
            S_LEN0: if (w_accept) w_state_nxt = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > C_MAX_N) begin
                        w_ack_set   = 1'b1;
                        w_ack_val   = C_ACK_ERR;
                        w_state_nxt = S_RESP;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: if (w_accept && (r_byte_idx == 2'd3) && w_last) w_state_nxt = S_CHK;
            S_CHK: begin
                if (w_accept) begin
                    w_ack_set   = 1'b1;
                    w_ack_val   = (r_data == r_chk) ? C_ACK_OK : C_ACK_ERR;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (!tx_full) begin
                    w_wr        = 1'b1;
                    w_state_nxt = (r_ack == C_ACK_OK) ? S_DONE : S_SYNC;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_SYNC;
        endcase
        if (w_timeout) begin
            w_ack_set   = 1'b1;
            w_ack_val   = C_ACK_TO;
            w_state_nxt = S_RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_chk       <= '0;
            r_ack       <= '0;
            r_to_cnt    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_owns_uart <= 1'b1;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept || !w_in_frame) r_to_cnt <= '0;
            else                         r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_ack_set) r_ack <= w_ack_val;
            if (w_accept) begin
                case (r_state)
                    S_LEN0: r_len[7:0] <= r_data;
                    S_LEN1: begin
                        r_len[15:8] <= r_data;
                        r_word_cnt  <= '0;
                        r_byte_idx  <= '0;
                        r_chk       <= '0;
                    end
                    S_DATA: begin
                        r_mem_wdata[{r_byte_idx, 3'b000} +: 8] <= r_data;
                        r_chk      <= r_chk ^ r_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_word_cnt[ADDR_W-1:0];
                            r_word_cnt <= w_word_nxt;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_wr && (r_ack == C_ACK_OK)) begin
                r_cpu_reset <= 1'b0;
                r_owns_uart <= 1'b0;
            end
        end
    end

    assign rd_uart   = w_accept;
    assign wr_uart   = w_wr;
    assign w_data    = r_ack;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign owns_uart = r_owns_uart;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Brief    : Self-checking bench for uart_boot_loader with a queue-based
//            RX FIFO model and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 100;
    localparam int C_MAXN  = 2 ** ADDR_W;
    localparam logic [7:0] C_K = 8'h4B;
    localparam logic [7:0] C_E = 8'h45;
    localparam logic [7:0] C_T = 8'h54;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full = 1'b0;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              owns_uart;

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .owns_uart(owns_uart)
    );

    always #5 clk = ~clk;

    // First-word-fall-through RX FIFO; reset flushes it.
    logic [7:0] rx_buf [0:255];
    int rx_head = 0;
    int rx_tail = 0;
    assign rx_empty = (rx_head == rx_tail);
    assign r_data   = rx_buf[rx_head[7:0]];
    always @(posedge clk or posedge reset) begin
        if (reset)        rx_head <= rx_tail;
        else if (rd_uart) rx_head <= rx_head + 1;
    end

    // Observation logs of TX acks and imem writes.
    logic [7:0]        ack_log [0:63];
    logic [ADDR_W-1:0] wa_log  [0:255];
    logic [31:0]       wd_log  [0:255];
    int ack_cnt = 0;
    int we_cnt  = 0;
    int clash   = 0;
    always @(negedge clk) begin
        if (wr_uart) begin
            ack_log[ack_cnt[5:0]] <= w_data;
            ack_cnt <= ack_cnt + 1;
        end
        if (mem_we) begin
            wa_log[we_cnt[7:0]] <= mem_addr;
            wd_log[we_cnt[7:0]] <= mem_data_q();
            we_cnt <= we_cnt + 1;
        end
        if (mem_we && wr_uart) clash <= clash + 1;
    end
    function automatic logic [31:0] mem_data_q();
        return mem_wdata;
    endfunction

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_words [0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_buf[rx_tail[7:0]] = b;
        rx_tail = rx_tail + 1;
    endtask

    task automatic fill_random(input int n);
        for (int w = 0; w < n; w++) exp_words[w] = $urandom;
    endtask

    // Frame: A5, N lo, N hi, 4*N little-endian data bytes, XOR checksum.
    task automatic send_frame(input int n, input bit bad_chk);
        logic [7:0] chk;
        logic [7:0] b;
        logic [15:0] n16;
        chk = 8'h00;
        n16 = n[15:0];
        push(8'hA5);
        push(n16[7:0]);
        push(n16[15:8]);
        if (n > C_MAXN) return;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = exp_words[w][8*k +: 8];
                chk = chk ^ b;
                push(b);
            end
        end
        push(bad_chk ? (chk ^ 8'h01) : chk);
    endtask

    task automatic wait_ack(input string tag, input int a0, input int budget, output int waited);
        waited = 0;
        while (ack_cnt == a0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ack_arrives"}, ack_cnt, a0 + 1);
    endtask

    task automatic expect_frame(input string tag, input int a0, input int we0,
                                input logic [7:0] ack, input int nwr);
        int waited;
        wait_ack(tag, a0, 1000, waited);
        check({tag, "_ack"}, {24'h0, ack_log[a0[5:0]]}, {24'h0, ack});
        check({tag, "_nwrites"}, we_cnt - we0, nwr);
        for (int i = 0; i < nwr; i++) begin
            check({tag, "_waddr"}, {28'h0, wa_log[(we0 + i) % 256]}, i);
            check({tag, "_wdata"}, wd_log[(we0 + i) % 256], exp_words[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int a0, we0, n, waited;
        repeat (2) @(negedge clk);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_w_data", w_data, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_owns_uart", owns_uart, 1);
        reset = 1'b0;
        @(negedge clk);

        // Bad checksum: words still land, ack E, core stays in reset.
        n = $urandom_range(1, C_MAXN);
        fill_random(n);
        a0 = ack_cnt; we0 = we_cnt;
        send_frame(n, 1'b1);
        expect_frame("badchk", a0, we0, C_E, n);
        repeat (3) @(negedge clk);
        check("badchk_cpu_reset", cpu_reset, 1);
        check("badchk_owns", owns_uart, 1);

        // Reference image with TX FIFO held full for 20+ cycles at the ack.
        exp_words[0] = 32'h44332211;
        exp_words[1] = 32'hDDCCBBAA;
        tx_full = 1'b1;
        a0 = ack_cnt; we0 = we_cnt;
        send_frame(2, 1'b0);
        waited = 0;
        while (rx_head != rx_tail && waited < 500) begin @(negedge clk); waited++; end
        repeat (22) @(negedge clk);
        check("hold_no_pulse", ack_cnt, a0);
        check("hold_w_data", w_data, C_K);
        check("hold_cpu_reset", cpu_reset, 1);
        tx_full = 1'b0;
        expect_frame("ref", a0, we0, C_K, 2);
        repeat (5) @(negedge clk);
        check("ref_single_pulse", ack_cnt, a0 + 1);
        check("ref_cpu_reset", cpu_reset, 0);
        check("ref_owns", owns_uart, 0);
        // DONE is terminal and never pops the RX FIFO.
        push(8'hA5);
        repeat (5) @(negedge clk);
        check("done_no_pop", rx_tail - rx_head, 1);
        do_reset();
        check("rerst_cpu_reset", cpu_reset, 1);
        check("rerst_owns", owns_uart, 1);

        // Oversized N rejected right after LEN1; trailing bytes are sync hunt.
        a0 = ack_cnt; we0 = we_cnt;
        send_frame(C_MAXN + 1, 1'b0);
        wait_ack("big", a0, 20, waited);
        check("big_ack", ack_log[a0[5:0]], C_E);
        push(8'h00); push(8'h11); push(8'h22);
        n = $urandom_range(1, C_MAXN);
        fill_random(n);
        a0 = ack_cnt;
        send_frame(n, 1'b0);
        expect_frame("afterbig", a0, we0, C_K, n);
        do_reset();

        // Partial word then silence: timeout ack, nothing written.
        a0 = ack_cnt; we0 = we_cnt;
        push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22);
        wait_ack("tmo", a0, 400, waited);
        check("tmo_ack", ack_log[a0[5:0]], C_T);
        check("tmo_not_early", 32'(waited >= 95), 1);
        check("tmo_nwrites", we_cnt - we0, 0);
        check("tmo_cpu_reset", cpu_reset, 1);

        // Reset in the middle of DATA after two words have been written.
        fill_random(4);
        we0 = we_cnt;
        push(8'hA5); push(8'h04); push(8'h00);
        for (int i = 0; i < 10; i++) push(exp_words[i / 4][8*(i % 4) +: 8]);
        repeat (4) @(negedge clk);
        check("mid_nwrites", we_cnt - we0, 2);
        check("mid_addr", mem_addr, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_mem_wdata", mem_wdata, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_w_data", w_data, 0);
        check("mid_rst_wr_uart", wr_uart, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_owns", owns_uart, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Leading junk dropped, empty image boots.
        a0 = ack_cnt; we0 = we_cnt;
        push(8'h00); push(8'hFF);
        send_frame(0, 1'b0);
        expect_frame("n0", a0, we0, C_K, 0);
        repeat (2) @(negedge clk);
        check("n0_cpu_reset", cpu_reset, 0);
        check("n0_owns", owns_uart, 0);
        check("no_we_with_wr", clash, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
